// File: rtl/ps2_keys_pkg.sv
// Shared constants for the PS/2 game-key tracker.
// Scancodes, key indices and the scancode-to-key lookup.
package ps2_keys_pkg;

    localparam int NUM_KEYS = 8;
    localparam int EV_W     = 9;
    localparam int REL_BIT  = 8;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_SPACE = 4;
    localparam int KEY_ENTER = 5;
    localparam int KEY_ESC   = 6;
    localparam int KEY_P     = 7;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(input logic [7:0] sc);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case (sc)
            SC_W:     r.idx = 3'(KEY_W);
            SC_A:     r.idx = 3'(KEY_A);
            SC_S:     r.idx = 3'(KEY_S);
            SC_D:     r.idx = 3'(KEY_D);
            SC_SPACE: r.idx = 3'(KEY_SPACE);
            SC_ENTER: r.idx = 3'(KEY_ENTER);
            SC_ESC:   r.idx = 3'(KEY_ESC);
            SC_P:     r.idx = 3'(KEY_P);
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only if a pop frees a slot that cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_pop;
    logic         w_push;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the strobeless PS/2 scan word into events by change detection,
// tracks held game keys and queues events for the game logic.
module ps2_key_tracker
    import ps2_keys_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit MAP_ONLY   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [EV_W-1:0] ps2_code,
    input  logic            ev_pop,
    input  logic            clr_ovf,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    output logic [7:0]      key_state,
    output logic            any_key,
    output logic            ovf
);

    logic [EV_W-1:0]     r_code;
    logic [EV_W-1:0]     r_prev;
    logic [NUM_KEYS-1:0] r_keys;
    logic                r_ovf;
    key_hit_t            w_key;
    logic                w_evt;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;

    assign w_evt  = (r_code != r_prev);
    assign w_key  = key_lookup(r_code[7:0]);
    assign w_push = w_evt & (w_key.hit | ~MAP_ONLY);
    assign w_pop  = ev_pop & ~w_empty;
    // a same-cycle pop frees the slot, so only a pop-less push is lost
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= '0;
            r_prev <= '0;
        end else begin
            r_code <= ps2_code;
            r_prev <= r_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keys <= '0;
        end else if (w_evt && w_key.hit) begin
            r_keys[w_key.idx] <= ~r_code[REL_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
        else if (clr_ovf) r_ovf <= 1'b0;
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_code),
        .pop   (ev_pop),
        .dout  (ev_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign ev_valid  = ~w_empty;
    assign key_state = r_keys;
    assign any_key   = |r_keys;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed + random bench for ps2_key_tracker, both MAP_ONLY settings
// side by side against a queue-based reference model.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] ps2_code = 9'h000;
    logic       ev_pop0 = 1'b0;
    logic       ev_pop1 = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       v0, v1, ak0, ak1, ovf0, ovf1;
    logic [8:0] d0, d1;
    logic [7:0] ks0, ks1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [7:0] m_ks0, m_ks1;
    bit         m_ovf0, m_ovf1;
    logic [8:0] last;

    logic [7:0] keymap [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23,
                               8'h29, 8'h5A, 8'h76, 8'h4D};
    logic [7:0] pool [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23,
                              8'h29, 8'h5A, 8'h76, 8'h4D,
                              8'h15, 8'h24, 8'h2B, 8'h34};

    always #5 clk = ~clk;

    ps2_key_tracker #(.FIFO_DEPTH(8), .MAP_ONLY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ps2_code(ps2_code),
        .ev_pop(ev_pop0), .clr_ovf(clr_ovf),
        .ev_valid(v0), .ev_data(d0), .key_state(ks0),
        .any_key(ak0), .ovf(ovf0)
    );

    ps2_key_tracker #(.FIFO_DEPTH(8), .MAP_ONLY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ps2_code(ps2_code),
        .ev_pop(ev_pop1), .clr_ovf(clr_ovf),
        .ev_valid(v1), .ev_data(d1), .key_state(ks1),
        .any_key(ak1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/v0"},   32'(v0),   32'(q0.size() != 0));
        chk({tag, "/d0"},   32'(d0),   32'(q0.size() != 0 ? q0[0] : 9'h0));
        chk({tag, "/ks0"},  32'(ks0),  32'(m_ks0));
        chk({tag, "/ak0"},  32'(ak0),  32'(m_ks0 != 8'h0));
        chk({tag, "/ovf0"}, 32'(ovf0), 32'(m_ovf0));
        chk({tag, "/v1"},   32'(v1),   32'(q1.size() != 0));
        chk({tag, "/d1"},   32'(d1),   32'(q1.size() != 0 ? q1[0] : 9'h0));
        chk({tag, "/ks1"},  32'(ks1),  32'(m_ks1));
        chk({tag, "/ak1"},  32'(ak1),  32'(m_ks1 != 8'h0));
        chk({tag, "/ovf1"}, 32'(ovf1), 32'(m_ovf1));
    endtask

    task automatic model_event(input logic [8:0] c, input bit p0,
                               input bit p1);
        bit hit = 1'b0;
        int idx = 0;
        for (int i = 0; i < 8; i++)
            if (keymap[i] == c[7:0]) begin
                hit = 1'b1;
                idx = i;
            end
        if (hit) begin
            m_ks0[idx] = ~c[8];
            m_ks1[idx] = ~c[8];
        end
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (q0.size() < 8) q0.push_back(c);
        else m_ovf0 = 1'b1;
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        if (hit) begin
            if (q1.size() < 8) q1.push_back(c);
            else m_ovf1 = 1'b1;
        end
    endtask

    task automatic send(input logic [8:0] c);
        ps2_code = c;
        if (c !== last) model_event(c, 1'b0, 1'b0);
        last = c;
        tick();
        tick();
    endtask

    task automatic pop_both();
        ev_pop0 = 1'b1;
        ev_pop1 = 1'b1;
        tick();
        ev_pop0 = 1'b0;
        ev_pop1 = 1'b0;
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        ps2_code = 9'h000;
        last = 9'h000;
        q0.delete();
        q1.delete();
        m_ks0 = 8'h0;
        m_ks1 = 8'h0;
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        #1;
        check_all(tag);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        last = 9'h000;
        q0.delete();
        q1.delete();
        m_ks0 = 8'h0;
        m_ks1 = 8'h0;
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        tick();
        rst = 1'b0;
        check_all("reset");
        repeat (5) tick();
        check_all("zero_no_event");

        // single press, latency and hold
        ps2_code = 9'h01D;
        tick();
        chk("lat_n1_ks", 32'(ks0), 32'h0);
        chk("lat_n1_v", 32'(v0), 32'h0);
        tick();
        chk("lat_n2_ks", 32'(ks0), 32'h1);
        chk("lat_n2_any", 32'(ak0), 32'h1);
        model_event(9'h01D, 1'b0, 1'b0);
        last = 9'h01D;
        repeat (20) tick();
        check_all("hold");
        pop_both();
        check_all("hold_one_event");
        send(9'h11D);
        chk("rel_ks", 32'(ks0), 32'h0);
        chk("rel_head", 32'(d0), 32'h11D);
        check_all("release");
        pop_both();
        pop_both();
        check_all("pop_empty_ignored");

        // reset mid-stream with events queued and W held
        send(9'h01D);
        send(9'h01C);
        send(9'h023);
        check_all("pre_reset");
        do_reset("async_reset");
        check_all("post_reset");

        // simultaneous keys and FIFO order
        send(9'h01C);
        send(9'h023);
        send(9'h11C);
        chk("simul_ks", 32'(ks0), 32'h08);
        check_all("simul");
        chk("order0", 32'(d0), 32'h01C);
        pop_both();
        chk("order1", 32'(d0), 32'h023);
        pop_both();
        chk("order2", 32'(d0), 32'h11C);
        pop_both();
        check_all("simul_drained");

        // overflow with 9 distinct codes
        do_reset("reset2");
        foreach (pool[i]) if (i < 9) send({1'b0, pool[i]});
        chk("ovf_set", 32'(ovf0), 32'h1);
        chk("ovf_ks", 32'(ks0), 32'hFF);
        check_all("overflow");
        clear_ovf();
        chk("ovf_clr", 32'(ovf0), 32'h0);
        check_all("ovf_cleared");

        // full FIFO with same-cycle push and pop
        ps2_code = 9'h029;
        model_event(9'h029, 1'b1, 1'b0);
        last = 9'h029;
        tick();
        ev_pop0 = 1'b1;
        tick();
        ev_pop0 = 1'b0;
        chk("full_pp_ovf", 32'(ovf0), 32'h0);
        check_all("full_push_pop");
        for (int i = 0; i < 8; i++) begin
            check_all("drain");
            if (i == 7) chk("tail_029", 32'(d0), 32'h029);
            pop_both();
        end
        check_all("drained");

        // MAP_ONLY filtering
        do_reset("reset3");
        send(9'h015);
        send(9'h05A);
        chk("map_head", 32'(d1), 32'h05A);
        chk("map_ks", 32'(ks1), 32'h20);
        check_all("map_only");
        pop_both();
        chk("map_one", 32'(v1), 32'h0);

        // random traffic
        do_reset("reset4");
        for (int n = 0; n < 60; n++) begin
            send({1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)]});
            check_all("rand_send");
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    pop_both();
                    check_all("rand_pop");
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                clear_ovf();
                check_all("rand_clr");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
